// File: rtl/processador_multiciclo_if.sv
// Shared instruction/data memory port of processador_multiciclo.
// The core drives the request side (master); the memory answers with data and ready (slave).
interface processador_multiciclo_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_addr, mem_re, mem_we, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_addr, mem_re, mem_we, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/processador_multiciclo.sv
// Multi-cycle MIPS-subset core with one shared memory port and an internal register bank.
// All architectural state advances only on clock edges where en=1 (display stepping tick).
module processador_multiciclo #(
  parameter int              ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] PC_INICIAL = '0,
  parameter logic [5:0]      OP_HALT    = 6'h3F
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  processador_multiciclo_if.master  mem,
  output logic [ADDR_W-1:0]         pc_atual,
  output logic [31:0]               alu_resultado,
  output logic [2:0]                estado,
  output logic [31:0]               instr_count,
  output logic                      parado
);
  typedef enum logic [2:0] {
    BUSCA  = 3'd0,
    DECOD  = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    PARADO = 3'd5
  } estado_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  estado_t           estado_r, estado_nxt_s;
  logic [ADDR_W-1:0] pc_r, pc_nxt_s, target_r;
  logic [31:0]       ir_r, a_r, b_r, mdr_r, alu_r, count_r;
  logic [31:0]       regs_r [32];

  logic              pc_we_s, ir_we_s, ab_we_s, alu_we_s, mdr_we_s, rf_we_s, retire_s;
  logic [4:0]        rf_waddr_s;
  logic [31:0]       rf_wdata_s;
  logic [31:0]       alu_s;
  logic              funct_ok_s;

  logic [5:0]        op_s, funct_s;
  logic [4:0]        rs_s, rt_s, rd_s;
  logic [31:0]       imm_s, pc4_s, branch_s;
  logic [ADDR_W-1:0] pc4_pc_s, jump_pc_s;

  assign op_s      = ir_r[31:26];
  assign rs_s      = ir_r[25:21];
  assign rt_s      = ir_r[20:16];
  assign rd_s      = ir_r[15:11];
  assign funct_s   = ir_r[5:0];
  assign imm_s     = {{16{ir_r[15]}}, ir_r[15:0]};
  assign pc4_s     = 32'(pc_r) + 32'd4;
  assign branch_s  = pc4_s + {imm_s[29:0], 2'b00};
  assign pc4_pc_s  = ADDR_W'(pc4_s);
  assign jump_pc_s = ADDR_W'({pc4_s[31:28], ir_r[25:0], 2'b00});

  // ALU: operands were latched in DECOD; funct_ok_s flags a supported R-type funct
  always_comb begin
    alu_s      = 32'd0;
    funct_ok_s = 1'b0;
    if (op_s == OP_R) begin
      funct_ok_s = 1'b1;
      case (funct_s)
        6'h20:   alu_s = a_r + b_r;
        6'h22:   alu_s = a_r - b_r;
        6'h24:   alu_s = a_r & b_r;
        6'h25:   alu_s = a_r | b_r;
        6'h2A:   alu_s = ($signed(a_r) < $signed(b_r)) ? 32'd1 : 32'd0;
        default: funct_ok_s = 1'b0;
      endcase
    end else if (op_s == OP_BEQ) begin
      alu_s = a_r - b_r;
    end else begin
      alu_s = a_r + imm_s;
    end
  end

  // Next-state and datapath control decode
  always_comb begin
    estado_nxt_s = estado_r;
    pc_we_s      = 1'b0;
    pc_nxt_s     = pc_r;
    ir_we_s      = 1'b0;
    ab_we_s      = 1'b0;
    alu_we_s     = 1'b0;
    mdr_we_s     = 1'b0;
    rf_we_s      = 1'b0;
    rf_waddr_s   = 5'd0;
    rf_wdata_s   = 32'd0;
    retire_s     = 1'b0;
    case (estado_r)
      BUSCA: begin
        if (mem.mem_ready) begin
          ir_we_s      = 1'b1;
          estado_nxt_s = DECOD;
        end else begin
          estado_nxt_s = BUSCA;
        end
      end
      DECOD: begin
        ab_we_s = 1'b1;
        if (op_s == OP_HALT) begin
          retire_s     = 1'b1;
          estado_nxt_s = PARADO;
        end else begin
          case (op_s)
            OP_J: begin
              pc_we_s      = 1'b1;
              pc_nxt_s     = jump_pc_s;
              retire_s     = 1'b1;
              estado_nxt_s = BUSCA;
            end
            OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ: estado_nxt_s = EXEC;
            default: begin
              pc_we_s      = 1'b1;
              pc_nxt_s     = pc4_pc_s;
              retire_s     = 1'b1;
              estado_nxt_s = BUSCA;
            end
          endcase
        end
      end
      EXEC: begin
        case (op_s)
          OP_BEQ: begin
            alu_we_s     = 1'b1;
            pc_we_s      = 1'b1;
            pc_nxt_s     = (alu_s == 32'd0) ? target_r : pc4_pc_s;
            retire_s     = 1'b1;
            estado_nxt_s = BUSCA;
          end
          OP_LW, OP_SW: begin
            alu_we_s     = 1'b1;
            estado_nxt_s = MEM;
          end
          OP_R: begin
            alu_we_s     = funct_ok_s;
            estado_nxt_s = WB;
          end
          default: begin
            alu_we_s     = 1'b1;
            estado_nxt_s = WB;
          end
        endcase
      end
      MEM: begin
        if (mem.mem_ready) begin
          if (op_s == OP_SW) begin
            pc_we_s      = 1'b1;
            pc_nxt_s     = pc4_pc_s;
            retire_s     = 1'b1;
            estado_nxt_s = BUSCA;
          end else begin
            mdr_we_s     = 1'b1;
            estado_nxt_s = WB;
          end
        end else begin
          estado_nxt_s = MEM;
        end
      end
      WB: begin
        pc_we_s      = 1'b1;
        pc_nxt_s     = pc4_pc_s;
        retire_s     = 1'b1;
        estado_nxt_s = BUSCA;
        case (op_s)
          OP_R: begin
            rf_we_s    = funct_ok_s;
            rf_waddr_s = rd_s;
            rf_wdata_s = alu_r;
          end
          OP_ADDI: begin
            rf_we_s    = 1'b1;
            rf_waddr_s = rt_s;
            rf_wdata_s = alu_r;
          end
          OP_LW: begin
            rf_we_s    = 1'b1;
            rf_waddr_s = rt_s;
            rf_wdata_s = mdr_r;
          end
          default: rf_we_s = 1'b0;
        endcase
      end
      PARADO:  estado_nxt_s = PARADO;
      default: estado_nxt_s = BUSCA;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_r <= BUSCA;
    end else if (en) begin
      estado_r <= estado_nxt_s;
    end
  end

  // PC, instruction, operand, result and retire-counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r     <= PC_INICIAL;
      ir_r     <= 32'd0;
      a_r      <= 32'd0;
      b_r      <= 32'd0;
      target_r <= '0;
      mdr_r    <= 32'd0;
      alu_r    <= 32'd0;
      count_r  <= 32'd0;
    end else if (en) begin
      if (pc_we_s)  pc_r  <= pc_nxt_s;
      if (ir_we_s)  ir_r  <= mem.mem_rdata;
      if (ab_we_s) begin
        a_r      <= regs_r[rs_s];
        b_r      <= regs_r[rt_s];
        target_r <= ADDR_W'(branch_s);
      end
      if (alu_we_s) alu_r   <= alu_s;
      if (mdr_we_s) mdr_r   <= mem.mem_rdata;
      if (retire_s) count_r <= count_r + 32'd1;
    end
  end

  // Register bank; $0 is never written so it always reads zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs_r[i] <= 32'd0;
    end else if (en && rf_we_s && (rf_waddr_s != 5'd0)) begin
      regs_r[rf_waddr_s] <= rf_wdata_s;
    end
  end

  assign mem.mem_re    = !reset && ((estado_r == BUSCA) || ((estado_r == MEM) && (op_s == OP_LW)));
  assign mem.mem_we    = !reset && (estado_r == MEM) && (op_s == OP_SW);
  assign mem.mem_addr  = (estado_r == MEM) ? alu_r[ADDR_W-1:0] : pc_r;
  assign mem.mem_wdata = b_r;

  assign pc_atual      = pc_r;
  assign alu_resultado = alu_r;
  assign estado        = estado_r;
  assign instr_count   = count_r;
  assign parado        = (estado_r == PARADO);
endmodule
